control_pipeline: RTL and testbench

CONTROL_PIPELINE -- requirements
Module: control_pipeline

---
 rtl/ctrl_pkg.sv | 102 ++++++++++
 rtl/control_pipeline_if.sv | 44 ++++
 rtl/control_decode.sv | 133 +++++++++++++
 rtl/control_pipeline.sv | 120 ++++++++++++
 tb/tb_control_pipeline.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared control types and encodings for the decode/EX/MEM/WB control pipeline.
// Holds the per-stage control structs, opcode and ALU code constants (base and
// M-extension range), immediate/mask/result selectors and the bubble values.
package ctrl_pkg;

  localparam int ALU_CODE_W = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 5'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 5'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 5'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 5'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 5'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_LUI  = 5'd10;
  // M ops occupy 16..23: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  localparam logic [ALU_CODE_W-1:0] ALU_M_BASE = 5'd16;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic [ALU_CODE_W-1:0] alu_control;
    logic                  alu_src_a;
    logic                  alu_src_b;
    logic [2:0]            immext_src;
    logic                  pc_adder_src;
    logic                  branch;
    logic                  jump;
    logic                  valid;
  } ex_ctrl_t;

  typedef struct packed {
    logic       datamem_write;
    logic [1:0] mask_type;
    logic       ext_type;
    logic       valid;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regfile_write;
    logic [1:0] final_result_src;
    logic       valid;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    logic      illegal;
    logic      is_div;
  } id_ex_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ex_mem_t;

  localparam ex_ctrl_t  EX_BUBBLE     = '0;
  localparam mem_ctrl_t MEM_BUBBLE    = '0;
  localparam wb_ctrl_t  WB_BUBBLE     = '0;
  localparam id_ex_t    ID_EX_BUBBLE  = '0;
  localparam ex_mem_t   EX_MEM_BUBBLE = '0;

  function automatic logic [ALU_CODE_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_pipeline_if.sv
// Bus between the instruction source / datapath and control_pipeline.
//   i_instr, i_valid, i_stall_d, i_flush_e : decode-side inputs
//   o_ex_*, o_mem_*, o_wb_*                : per-stage control outputs
//   o_busy, o_illegal                      : multicycle hold, EX illegal flag
// master: instruction source side; slave: control_pipeline.
interface control_pipeline_if #(parameter int P_ALU_CTRL_W = 5);
  logic [31:0]             i_instr;
  logic                    i_valid;
  logic                    i_stall_d;
  logic                    i_flush_e;
  logic [P_ALU_CTRL_W-1:0] o_ex_alu_control;
  logic                    o_ex_alu_src_a;
  logic                    o_ex_alu_src_b;
  logic [2:0]              o_ex_immext_src;
  logic                    o_ex_pc_adder_src;
  logic                    o_ex_branch;
  logic                    o_ex_jump;
  logic                    o_ex_valid;
  logic                    o_mem_datamem_write;
  logic [1:0]              o_mem_mask_type;
  logic                    o_mem_ext_type;
  logic                    o_mem_valid;
  logic                    o_wb_regfile_write;
  logic [1:0]              o_wb_final_result_src;
  logic                    o_wb_valid;
  logic                    o_busy;
  logic                    o_illegal;

  modport master (
    output i_instr, i_valid, i_stall_d, i_flush_e,
    input  o_ex_alu_control, o_ex_alu_src_a, o_ex_alu_src_b, o_ex_immext_src,
           o_ex_pc_adder_src, o_ex_branch, o_ex_jump, o_ex_valid,
           o_mem_datamem_write, o_mem_mask_type, o_mem_ext_type, o_mem_valid,
           o_wb_regfile_write, o_wb_final_result_src, o_wb_valid, o_busy, o_illegal
  );

  modport slave (
    input  i_instr, i_valid, i_stall_d, i_flush_e,
    output o_ex_alu_control, o_ex_alu_src_a, o_ex_alu_src_b, o_ex_immext_src,
           o_ex_pc_adder_src, o_ex_branch, o_ex_jump, o_ex_valid,
           o_mem_datamem_write, o_mem_mask_type, o_mem_ext_type, o_mem_valid,
           o_wb_regfile_write, o_wb_final_result_src, o_wb_valid, o_busy, o_illegal
  );
endinterface

// File: rtl/control_decode.sv
// Combinational RV32I(+M) control decode.
//   i_instr   : instruction word
//   o_ex/o_mem/o_wb : stage control structs (valid set for legal encodings)
//   o_illegal : unsupported encoding; o_ex carries only valid=1
//   o_is_div  : DIV/DIVU/REM/REMU (needs the multicycle EX slot)
module control_decode import ctrl_pkg::*; #(
  parameter int P_EN_M_EXT = 1
) (
  input  logic [31:0] i_instr,
  output ex_ctrl_t    o_ex,
  output mem_ctrl_t   o_mem,
  output wb_ctrl_t    o_wb,
  output logic        o_illegal,
  output logic        o_is_div
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       unused_fields;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  // register indices and immediate bits are datapath concerns
  assign unused_fields = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    o_ex      = EX_BUBBLE;
    o_mem     = MEM_BUBBLE;
    o_wb      = WB_BUBBLE;
    o_illegal = 1'b0;
    o_is_div  = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OP_REG: begin
        o_wb.regfile_write = 1'b1;
        if (funct7 == F7_MEXT) begin
          if (P_EN_M_EXT != 0) begin
            o_ex.alu_control = ALU_M_BASE + {2'b00, funct3};
            o_is_div         = funct3[2];
          end else begin
            legal = 1'b0;
          end
        end else if (funct7 == F7_BASE ||
                     (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          o_ex.alu_control = alu_base(funct3, funct7[5]);
        end else begin
          legal = 1'b0;
        end
      end
      OP_IMM: begin
        o_ex.alu_src_b     = 1'b1;
        o_ex.immext_src    = IMM_I;
        // bit 30 only selects SRAI; for ADDI it is immediate data
        o_ex.alu_control   = alu_base(funct3, (funct3 == 3'b101) & i_instr[30]);
        o_wb.regfile_write = 1'b1;
      end
      OP_LOAD: begin
        o_ex.alu_src_b        = 1'b1;
        o_ex.immext_src       = IMM_I;
        o_ex.alu_control      = ALU_ADD;
        o_mem.mask_type       = funct3[1:0];
        o_mem.ext_type        = funct3[2];
        o_wb.regfile_write    = 1'b1;
        o_wb.final_result_src = RES_MEM;
        legal = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
      end
      OP_STORE: begin
        o_ex.alu_src_b      = 1'b1;
        o_ex.immext_src     = IMM_S;
        o_ex.alu_control    = ALU_ADD;
        o_mem.datamem_write = 1'b1;
        o_mem.mask_type     = funct3[1:0];
        legal = !funct3[2] && (funct3[1:0] != 2'b11);
      end
      OP_BRANCH: begin
        o_ex.branch     = 1'b1;
        o_ex.immext_src = IMM_B;
        case (funct3[2:1])
          2'b00:   o_ex.alu_control = ALU_SUB;
          2'b10:   o_ex.alu_control = ALU_SLT;
          2'b11:   o_ex.alu_control = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        o_ex.jump             = 1'b1;
        o_ex.immext_src       = IMM_J;
        o_wb.regfile_write    = 1'b1;
        o_wb.final_result_src = RES_PC4;
      end
      OP_JALR: begin
        o_ex.jump             = 1'b1;
        o_ex.pc_adder_src     = 1'b1;
        o_ex.alu_src_b        = 1'b1;
        o_ex.immext_src       = IMM_I;
        o_wb.regfile_write    = 1'b1;
        o_wb.final_result_src = RES_PC4;
        legal = (funct3 == 3'b000);
      end
      OP_LUI: begin
        o_ex.alu_src_b     = 1'b1;
        o_ex.immext_src    = IMM_U;
        o_ex.alu_control   = ALU_LUI;
        o_wb.regfile_write = 1'b1;
      end
      OP_AUIPC: begin
        o_ex.alu_src_a     = 1'b1;
        o_ex.alu_src_b     = 1'b1;
        o_ex.immext_src    = IMM_U;
        o_wb.regfile_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      o_ex.valid  = 1'b1;
      o_mem.valid = 1'b1;
      o_wb.valid  = 1'b1;
    end else begin
      // marker bubble: occupies EX for one slot, never reaches MEM/WB
      o_ex       = EX_BUBBLE;
      o_ex.valid = 1'b1;
      o_mem      = MEM_BUBBLE;
      o_wb       = WB_BUBBLE;
      o_illegal  = 1'b1;
      o_is_div   = 1'b0;
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers plus the divide hold FSM.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : decode inputs, per-stage control outputs, o_busy, o_illegal
//
//   state      | meaning
//   S_IDLE     | single-cycle flow, ID/EX loads every cycle
//   S_DIV_BUSY | divide occupying EX, ID/EX held, EX/MEM fed bubbles
module control_pipeline import ctrl_pkg::*; #(
  parameter int P_EN_M_EXT   = 1,
  parameter int P_DIV_CYCLES = 32,
  parameter int P_ALU_CTRL_W = 5
) (
  input logic          i_clk,
  input logic          i_rst,
  control_pipeline_if.slave bus
);

  localparam int CNT_W = $clog2(P_DIV_CYCLES + 1);

  typedef enum logic {S_IDLE = 1'b0, S_DIV_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  id_ex_t           id_ex_q, id_ex_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  wb_ctrl_t         mem_wb_q, mem_wb_d;
  ex_ctrl_t         dec_ex;
  mem_ctrl_t        dec_mem;
  wb_ctrl_t         dec_wb;
  logic             dec_illegal, dec_is_div;
  logic             busy;

  control_decode #(.P_EN_M_EXT(P_EN_M_EXT)) u_decode (
    .i_instr   (bus.i_instr),
    .o_ex      (dec_ex),
    .o_mem     (dec_mem),
    .o_wb      (dec_wb),
    .o_illegal (dec_illegal),
    .o_is_div  (dec_is_div)
  );

  assign busy = (state_q == S_DIV_BUSY);

  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.i_flush_e) begin
      id_ex_d = ID_EX_BUBBLE;
    end else if (busy) begin
      id_ex_d = id_ex_q;
    end else if (!bus.i_valid || bus.i_stall_d) begin
      id_ex_d = ID_EX_BUBBLE;
    end else begin
      id_ex_d = '{ex: dec_ex, mem: dec_mem, wb: dec_wb,
                  illegal: dec_illegal, is_div: dec_is_div};
    end
    ex_mem_d = busy ? EX_MEM_BUBBLE : '{mem: id_ex_q.mem, wb: id_ex_q.wb};
    mem_wb_d = ex_mem_q.wb;
  end

  // counter holds remaining EX cycles after the current one; exit at 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (id_ex_d.is_div && (P_DIV_CYCLES > 1)) begin
          state_d = S_DIV_BUSY;
          cnt_d   = CNT_W'(P_DIV_CYCLES - 1);
        end
      end
      S_DIV_BUSY: begin
        if (bus.i_flush_e || cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      id_ex_q  <= ID_EX_BUBBLE;
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= WB_BUBBLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.o_ex_alu_control      = P_ALU_CTRL_W'(id_ex_q.ex.alu_control);
  assign bus.o_ex_alu_src_a        = id_ex_q.ex.alu_src_a;
  assign bus.o_ex_alu_src_b        = id_ex_q.ex.alu_src_b;
  assign bus.o_ex_immext_src       = id_ex_q.ex.immext_src;
  assign bus.o_ex_pc_adder_src     = id_ex_q.ex.pc_adder_src;
  assign bus.o_ex_branch           = id_ex_q.ex.branch;
  assign bus.o_ex_jump             = id_ex_q.ex.jump;
  assign bus.o_ex_valid            = id_ex_q.ex.valid;
  assign bus.o_illegal             = id_ex_q.illegal;
  assign bus.o_mem_datamem_write   = ex_mem_q.mem.datamem_write;
  assign bus.o_mem_mask_type       = ex_mem_q.mem.mask_type;
  assign bus.o_mem_ext_type        = ex_mem_q.mem.ext_type;
  assign bus.o_mem_valid           = ex_mem_q.mem.valid;
  assign bus.o_wb_regfile_write    = mem_wb_q.regfile_write;
  assign bus.o_wb_final_result_src = mem_wb_q.final_result_src;
  assign bus.o_wb_valid            = mem_wb_q.valid;
  assign bus.o_busy                = busy;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: dut_a (defaults) is scoreboarded at MEM/WB;
// dut_b (single-cycle divide) and dut_c (M disabled) share the same stimulus.
module tb_control_pipeline;

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_DIV = 32'h0220C0B3;
  localparam logic [31:0] I_SW  = 32'h0020A023;
  localparam logic [31:0] I_MUL = 32'h023100B3;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        valid, stall, flush;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  mem_exp_q[$];   // {datamem_write, mask_type, ext_type}
  logic [2:0]  wb_exp_q[$];    // {regfile_write, final_result_src}
  logic [24:0] a_outs;
  int          busy_cnt, first_mem, hold_bad, c_busy, leak;
  logic        b_mem;

  always #5 clk = ~clk;

  control_pipeline_if #(.P_ALU_CTRL_W(5)) ifa ();
  control_pipeline_if #(.P_ALU_CTRL_W(5)) ifb ();
  control_pipeline_if #(.P_ALU_CTRL_W(5)) ifc ();

  assign ifa.i_instr = instr;  assign ifa.i_valid = valid;
  assign ifa.i_stall_d = stall; assign ifa.i_flush_e = flush;
  assign ifb.i_instr = instr;  assign ifb.i_valid = valid;
  assign ifb.i_stall_d = stall; assign ifb.i_flush_e = flush;
  assign ifc.i_instr = instr;  assign ifc.i_valid = valid;
  assign ifc.i_stall_d = stall; assign ifc.i_flush_e = flush;

  control_pipeline #(.P_EN_M_EXT(1), .P_DIV_CYCLES(32), .P_ALU_CTRL_W(5))
    dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  control_pipeline #(.P_EN_M_EXT(1), .P_DIV_CYCLES(1), .P_ALU_CTRL_W(5))
    dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));
  control_pipeline #(.P_EN_M_EXT(0), .P_DIV_CYCLES(32), .P_ALU_CTRL_W(5))
    dut_c (.i_clk(clk), .i_rst(rst), .bus(ifc));

  assign a_outs = {ifa.o_ex_alu_control, ifa.o_ex_alu_src_a, ifa.o_ex_alu_src_b,
                   ifa.o_ex_immext_src, ifa.o_ex_pc_adder_src, ifa.o_ex_branch,
                   ifa.o_ex_jump, ifa.o_ex_valid, ifa.o_mem_datamem_write,
                   ifa.o_mem_mask_type, ifa.o_mem_ext_type, ifa.o_mem_valid,
                   ifa.o_wb_regfile_write, ifa.o_wb_final_result_src, ifa.o_wb_valid,
                   ifa.o_busy, ifa.o_illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (n) tick();
  endtask

  always @(negedge clk) begin : scoreboard
    logic [3:0] me;
    logic [2:0] we;
    if (ifa.o_mem_valid === 1'b1) begin
      if (mem_exp_q.size() == 0) check("mem_unexpected", 32'(ifa.o_mem_valid), 32'd0);
      else begin
        me = mem_exp_q.pop_front();
        check("mem_ctrl", 32'({ifa.o_mem_datamem_write, ifa.o_mem_mask_type,
                               ifa.o_mem_ext_type}), 32'(me));
      end
    end
    if (ifa.o_wb_valid === 1'b1) begin
      if (wb_exp_q.size() == 0) check("wb_unexpected", 32'(ifa.o_wb_valid), 32'd0);
      else begin
        we = wb_exp_q.pop_front();
        check("wb_ctrl", 32'({ifa.o_wb_regfile_write, ifa.o_wb_final_result_src}), 32'(we));
      end
    end
  end

  task automatic leak_scan(input string tag);
    leak = 0;
    for (int k = 0; k < 40; k++) begin
      if (ifa.o_mem_valid || ifa.o_wb_valid || ifa.o_busy) leak++;
      tick();
    end
    check(tag, 32'(leak), 32'd0);
  endtask

  initial begin
    rst = 1'b1; instr = '0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) tick();
    check("reset_outs_a", 32'(a_outs), 32'd0);
    check("reset_flags_bc", 32'({ifb.o_busy, ifb.o_illegal, ifc.o_busy, ifc.o_illegal}), 32'd0);
    rst = 1'b0;
    tick();

    // ADD
    mem_exp_q.push_back(4'b0000); wb_exp_q.push_back(3'b100);
    instr = I_ADD; valid = 1'b1; tick();
    check("add_alu", 32'(ifa.o_ex_alu_control), 32'd0);
    check("add_src_b", 32'(ifa.o_ex_alu_src_b), 32'd0);
    check("add_ex_valid", 32'({ifa.o_ex_valid, ifa.o_illegal}), 32'b10);
    valid = 1'b0; tick(); tick();
    check("add_wb", 32'({ifa.o_wb_regfile_write, ifa.o_wb_valid}), 32'b11);
    idle(2);

    // SW with a stall on its first cycle
    instr = I_SW; valid = 1'b1; stall = 1'b1; tick();
    check("sw_stall_bubble", 32'(ifa.o_ex_valid), 32'd0);
    stall = 1'b0;
    mem_exp_q.push_back(4'b1100); wb_exp_q.push_back(3'b000);
    tick();
    check("sw_ex_valid", 32'(ifa.o_ex_valid), 32'd1);
    valid = 1'b0; tick();
    check("sw_mem", 32'({ifa.o_mem_datamem_write, ifa.o_mem_mask_type}), 32'b110);
    idle(3);

    // illegal encoding
    instr = I_BAD; valid = 1'b1; tick();
    check("ill_flag", 32'({ifa.o_illegal, ifa.o_ex_valid}), 32'b11);
    check("ill_ex_bubble", 32'(a_outs[24:12]), 32'd0);
    valid = 1'b0; tick();
    check("ill_one_cycle", 32'(ifa.o_illegal), 32'd0);
    idle(3);

    // MUL is single-cycle
    mem_exp_q.push_back(4'b0000); wb_exp_q.push_back(3'b100);
    instr = I_MUL; valid = 1'b1; tick();
    check("mul_alu", 32'(ifa.o_ex_alu_control), 32'd16);
    check("mul_not_busy", 32'(ifa.o_busy), 32'd0);
    idle(3);

    // DIV: 32 EX cycles, ID/EX held (also under stall), instr ignored while busy
    mem_exp_q.push_back(4'b0000); wb_exp_q.push_back(3'b100);
    instr = I_DIV; valid = 1'b1; tick();
    check("div_alu", 32'(ifa.o_ex_alu_control), 32'd20);
    check("div_b_single", 32'({ifb.o_busy, ifb.o_ex_valid, ifb.o_ex_alu_control}), 32'b0110100);
    check("div_c_illegal", 32'({ifc.o_illegal, ifc.o_busy}), 32'b10);
    busy_cnt = 0; first_mem = 0; hold_bad = 0; c_busy = 0; b_mem = 1'b0;
    instr = I_ADD;
    for (int k = 1; k <= 40; k++) begin
      if (ifa.o_busy) busy_cnt++;
      if (ifa.o_mem_valid && first_mem == 0) first_mem = k;
      if (k <= 32 && (ifa.o_ex_alu_control != 5'd20 || !ifa.o_ex_valid)) hold_bad++;
      if (ifc.o_busy) c_busy++;
      if (k == 2) b_mem = ifb.o_mem_valid;
      valid = ifa.o_busy;
      stall = ifa.o_busy && (k % 2 == 1);
      tick();
    end
    check("div_busy_cycles", 32'(busy_cnt), 32'd31);
    check("div_mem_cycle", 32'(first_mem), 32'd33);
    check("div_ex_hold", 32'(hold_bad), 32'd0);
    check("div_c_never_busy", 32'(c_busy), 32'd0);
    check("div_b_mem_next", 32'(b_mem), 32'd1);
    idle(3);

    // flush at busy cycle 5
    instr = I_DIV; valid = 1'b1; tick();
    valid = 1'b0; repeat (4) tick();
    check("flush_pre_busy", 32'(ifa.o_busy), 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_busy_off", 32'({ifa.o_busy, ifa.o_ex_valid}), 32'd0);
    leak_scan("flush_no_leak");

    // reset mid-divide
    instr = I_DIV; valid = 1'b1; tick();
    valid = 1'b0; repeat (6) tick();
    check("rst_pre_busy", 32'(ifa.o_busy), 32'd1);
    rst = 1'b1; tick();
    check("rst_outs", 32'(a_outs), 32'd0);
    rst = 1'b0;
    leak_scan("rst_no_leak");

    idle(2);
    check("mem_q_drained", 32'(mem_exp_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
